mem_access_unit: RTL and testbench

Memory-stage data-memory access controller for the pipelined RISC-V core. It issues load and store requests from the M stage to a handshaked data memory, generating word-aligned addresses, byte enables and lane-replicated store data. It stalls the pipeline until each access completes. For the load extender in WB it registers the raw read word together with the load type and the address byte offset.

---
 rtl/mem_access_unit.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// mem_access_unit
// M-stage data-memory access controller. It turns a load or store in M into a
// single handshaked request to data memory. It holds the pipeline until the
// access completes and registers the raw read word for the WB load extender.
//
// Ports
//   clk, reset                 core clock (rising edge), async active-high reset
//   MemReadM, MemWriteM        M-stage load / store (store wins if both are set)
//   LoadTypeM, StoreTypeM      access type: LB/LH/LW/LBU/LHU, SB/SH/SW
//   ALUResultM, WriteDataM     effective byte address, store source value
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_be          registered request to memory
//   mem_ready, mem_rvalid,
//   mem_rdata                  memory accept / read response
//   StallMem                   holds PC/F/D/E/M pipeline registers
//   MisalignM                  misaligned-access flag, raised in IDLE only
//   ReadDataW, LoadTypeW,
//   addr_offsetW, LoadValidW   captured load result for WB
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  LoadTypeM,
  input  logic [1:0]  StoreTypeM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        StallMem,
  output logic        MisalignM,
  output logic [31:0] ReadDataW,
  output logic [2:0]  LoadTypeW,
  output logic [1:0]  addr_offsetW,
  output logic        LoadValidW
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        access_s;
  logic        half_s;
  logic        word_s;
  logic [2:0]  ltype_r;
  logic [1:0]  off_r;

  // Byte enables of a store within the addressed word.
  function automatic logic [3:0] store_be(input logic [1:0] stype, input logic [1:0] off);
    logic [3:0] be;
    case (stype)
      2'b01:   be = 4'b0001 << off;
      2'b10:   be = 4'b0011 << off;
      2'b11:   be = 4'b1111;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated on every lane so that the enabled lanes carry it.
  function automatic logic [31:0] store_data(input logic [1:0] stype, input logic [31:0] wd);
    logic [31:0] d;
    case (stype)
      2'b01:   d = {4{wd[7:0]}};
      2'b10:   d = {2{wd[15:0]}};
      2'b11:   d = wd;
      default: d = wd;
    endcase
    return d;
  endfunction

  // Misalignment detection. The store type governs when MemWriteM is set.
  always_comb begin
    half_s    = 1'b0;
    word_s    = 1'b0;
    MisalignM = 1'b0;
    if (MemWriteM) begin
      half_s = (StoreTypeM == 2'b10);
      word_s = (StoreTypeM == 2'b11);
    end else begin
      half_s = (LoadTypeM == 3'b010) || (LoadTypeM == 3'b101);
      word_s = (LoadTypeM == 3'b011);
    end
    if ((state_r == IDLE) && (MemReadM || MemWriteM)) begin
      MisalignM = (half_s && ALUResultM[0]) || (word_s && (ALUResultM[1:0] != 2'b00));
    end else begin
      MisalignM = 1'b0;
    end
  end

  // Access detection and pipeline stall.
  always_comb begin
    access_s = (MemReadM || MemWriteM) && !MisalignM;
    StallMem = ((state_r == IDLE) && access_s) || (state_r == REQ) || (state_r == WAIT);
  end

  // Next-state logic of the access sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (access_s) begin
          state_next_s = REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_next_s = mem_we ? DONE : WAIT;
        end else begin
          state_next_s = REQ;
        end
      end
      WAIT: begin
        // mem_rvalid is only honoured here, never in the acceptance cycle.
        if (mem_rvalid) begin
          state_next_s = DONE;
        end else begin
          state_next_s = WAIT;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request registers; they drive mem_* directly and stay frozen while in REQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_be    <= 4'b0000;
      ltype_r   <= 3'b000;
      off_r     <= 2'b00;
    end else begin
      mem_req <= (state_next_s == REQ);
      if ((state_r == IDLE) && access_s) begin
        mem_addr <= {ALUResultM[31:2], 2'b00};
        mem_we   <= MemWriteM;
        mem_be   <= MemWriteM ? store_be(StoreTypeM, ALUResultM[1:0]) : 4'b1111;
        mem_wdata <= MemWriteM ? store_data(StoreTypeM, WriteDataM) : 32'h0000_0000;
        ltype_r  <= LoadTypeM;
        off_r    <= ALUResultM[1:0];
      end
    end
  end

  // WB-side load capture and the one-cycle load-valid pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ReadDataW    <= 32'h0000_0000;
      LoadTypeW    <= 3'b000;
      addr_offsetW <= 2'b00;
      LoadValidW   <= 1'b0;
    end else begin
      if ((state_r == WAIT) && mem_rvalid) begin
        ReadDataW    <= mem_rdata;
        LoadTypeW    <= ltype_r;
        addr_offsetW <= off_r;
      end
      LoadValidW <= (state_r == DONE) && !mem_we;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
// Self-checking bench for mem_access_unit: directed scenarios followed by
// randomized accesses against a byte-lane reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  LoadTypeM;
  logic [1:0]  StoreTypeM;
  logic [31:0] ALUResultM, WriteDataM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        StallMem, MisalignM;
  logic [31:0] ReadDataW;
  logic [2:0]  LoadTypeW;
  logic [1:0]  addr_offsetW;
  logic        LoadValidW;

  int checks = 0;
  int failures = 0;

  // Reference state of the WB registers and the pending load-valid pulse
  logic [31:0] exp_rdw = 32'h0;
  logic [2:0]  exp_ltw = 3'b000;
  logic [1:0]  exp_offw = 2'b00;
  logic        pending_lv = 1'b0;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .LoadTypeM(LoadTypeM), .StoreTypeM(StoreTypeM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .StallMem(StallMem), .MisalignM(MisalignM),
    .ReadDataW(ReadDataW), .LoadTypeW(LoadTypeW),
    .addr_offsetW(addr_offsetW), .LoadValidW(LoadValidW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Access size in bytes; the store type decides when a store is present.
  function automatic int acc_size(input logic wr, input logic [2:0] lt, input logic [1:0] st);
    if (wr) return (st == 2'b01) ? 1 : ((st == 2'b10) ? 2 : 4);
    return (lt == 3'b001 || lt == 3'b100) ? 1 : ((lt == 3'b010 || lt == 3'b101) ? 2 : 4);
  endfunction

  task automatic check_wregs(input string tag);
    chk({tag, "_rdw"}, ReadDataW, exp_rdw);
    chk({tag, "_ltw"}, 32'(LoadTypeW), 32'(exp_ltw));
    chk({tag, "_offw"}, 32'(addr_offsetW), 32'(exp_offw));
  endtask

  task automatic drive_idle();
    MemReadM = 1'b0; MemWriteM = 1'b0; LoadTypeM = 3'b000; StoreTypeM = 2'b00;
    ALUResultM = $urandom; WriteDataM = $urandom;
  endtask

  // One cycle with no instruction in M; stray rvalid must be ignored.
  task automatic idle_cycle();
    @(negedge clk);
    drive_idle();
    mem_ready = 1'b0; mem_rvalid = 1'($urandom); mem_rdata = $urandom;
    #1;
    chk("idle_lv", 32'(LoadValidW), 32'(pending_lv));
    pending_lv = 1'b0;
    chk("idle_stall", 32'(StallMem), 32'h0);
    chk("idle_req", 32'(mem_req), 32'h0);
  endtask

  // Present one instruction in M, act as the memory, and check everything.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] lt,
                            input logic [1:0] st, input logic [31:0] addr,
                            input logic [31:0] wd, input int rdy_dly, input int rv_dly,
                            input logic [31:0] rdata, input logic spur);
    int size, off, exp_stall, stalls, req_cycles, wait_cycles;
    logic mis, accepted, done;
    logic [3:0]  ebe;
    logic [31:0] ewd, eaddr;
    size  = acc_size(wr, lt, st);
    off   = int'(addr % 32'd4);
    mis   = (off % size) != 0;
    eaddr = (addr / 32'd4) * 32'd4;
    for (int i = 0; i < 4; i++) begin
      ebe[i] = !wr || ((i >= off) && (i < off + size));
      ewd[8*i +: 8] = wd[8*(i % size) +: 8];
    end
    exp_stall = wr ? (2 + rdy_dly) : (3 + rdy_dly + rv_dly);

    @(negedge clk);
    MemReadM = rd; MemWriteM = wr; LoadTypeM = lt; StoreTypeM = st;
    ALUResultM = addr; WriteDataM = wd;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
    #1;
    chk("lv_pulse", 32'(LoadValidW), 32'(pending_lv));
    pending_lv = 1'b0;
    chk("misalign", 32'(MisalignM), 32'(mis));
    if (mis) begin
      chk("mis_stall", 32'(StallMem), 32'h0);
      chk("mis_req", 32'(mem_req), 32'h0);
      idle_cycle();
      check_wregs("mis");
      return;
    end

    stalls = 0; req_cycles = 0; wait_cycles = 0; accepted = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (!StallMem) begin
        done = 1'b1;
      end else begin
        stalls++;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
        if (mem_req) begin
          chk("req_addr", mem_addr, eaddr);
          chk("req_we", 32'(mem_we), 32'(wr));
          chk("req_be", 32'(mem_be), 32'(ebe));
          if (wr) chk("req_wdata", mem_wdata, ewd);
          if (req_cycles == rdy_dly) begin
            mem_ready = 1'b1;
            accepted = 1'b1;
          end
          req_cycles++;
          if (spur) mem_rvalid = 1'($urandom);
        end else if (accepted) begin
          if (wait_cycles == rv_dly) begin
            mem_rvalid = 1'b1;
            mem_rdata = rdata;
          end
          wait_cycles++;
        end
        @(negedge clk); #1;
      end
    end
    chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    chk("done_req", 32'(mem_req), 32'h0);
    chk("done_lv", 32'(LoadValidW), 32'h0);
    if (!wr) begin
      exp_rdw = rdata; exp_ltw = lt; exp_offw = 2'(off);
    end
    check_wregs("done");
    pending_lv = !wr;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"}, 32'(mem_req), 32'h0);
    chk({tag, "_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_addr"}, mem_addr, 32'h0);
    chk({tag, "_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_be"}, 32'(mem_be), 32'h0);
    chk({tag, "_lv"}, 32'(LoadValidW), 32'h0);
    check_wregs(tag);
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    chk("reset_stall", 32'(StallMem), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // LB 0x1003, zero-wait
    run_access(1'b1, 1'b0, 3'b001, 2'b00, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_1234, 1'b0);
    // SH 0x2002 back-to-back after the load
    run_access(1'b0, 1'b1, 3'b000, 2'b10, 32'h0000_2002, 32'hDEAD_BEEF, 0, 0, 32'h0, 1'b0);
    idle_cycle();
    // SB 0x0001
    run_access(1'b0, 1'b1, 3'b000, 2'b01, 32'h0000_0001, 32'h0000_00A5, 0, 0, 32'h0, 1'b0);
    // LW 0x3001 misaligned
    run_access(1'b1, 1'b0, 3'b011, 2'b00, 32'h0000_3001, 32'h0, 0, 0, 32'h0, 1'b0);
    // LHU with 4 cycles of ready low, rvalid 2 late, spurious rvalid during REQ
    run_access(1'b1, 1'b0, 3'b101, 2'b00, 32'h0000_4002, 32'h0, 4, 2, 32'h1234_5678, 1'b1);
    idle_cycle();

    // Reset in the middle of WAIT
    @(negedge clk);
    MemReadM = 1'b1; MemWriteM = 1'b0; LoadTypeM = 3'b011; ALUResultM = 32'h0000_6004;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    #1;
    chk("rst_seq_stall0", 32'(StallMem), 32'h1);
    @(negedge clk); #1;
    chk("rst_seq_req", 32'(mem_req), 32'h1);
    mem_ready = 1'b1;
    @(negedge clk); #1;
    mem_ready = 1'b0;
    chk("rst_seq_wait_stall", 32'(StallMem), 32'h1);
    chk("rst_seq_wait_req", 32'(mem_req), 32'h0);
    reset = 1'b1;
    MemReadM = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    #1;
    exp_rdw = 32'h0; exp_ltw = 3'b000; exp_offw = 2'b00; pending_lv = 1'b0;
    check_all_zero("rst_mid");
    chk("rst_mid_stall", 32'(StallMem), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_cycle();
    idle_cycle();
    check_wregs("rst_after");
    // SW after reset release
    run_access(1'b0, 1'b1, 3'b000, 2'b11, 32'h0000_5000, 32'hCAFE_F00D, 1, 0, 32'h0, 1'b0);

    // Randomized accesses, back-to-back or separated by idle cycles
    for (int n = 0; n < 60; n++) begin
      int sel;
      logic rd, wr;
      sel = $urandom_range(0, 2);
      rd = (sel != 1);
      wr = (sel != 0);
      run_access(rd, wr, 3'($urandom_range(1, 5)), 2'($urandom_range(1, 3)), $urandom,
                 $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                 1'($urandom));
      repeat ($urandom_range(0, 1)) idle_cycle();
    end
    idle_cycle();
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
